rotate_scan_ctrl: RTL
=====================

Name: rotate_scan_ctrl

Overview:
- Initiator/driver for the rotated-image coordinate unit (the rotate-coordinate responder); the rotator itself stays outside this block.
- On start it raster-scans every screen pixel, sends (H, V, angle) to the rotator, and waits for the rotated source coordinate.
- It then fetches the source pixel from image SRAM through a req/ack handshake, or substitutes a background value when the rotator flags out-of-range.
- It streams pixels to the frame writer with a valid/ready handshake. Sits between game control and the display/frame-buffer path.

Parameters:
- IMAGE_SIZE, 128: square image edge in pixels; must be a power of two.
- COOR_WIDTH, 7: log2(IMAGE_SIZE); width of H and V.
- ANG_WIDTH, 9: signed angle width, in degrees, range -180..180.
- PIX_WIDTH, 16: pixel data width.
- BG_PIXEL, 16'h0000: pixel emitted for out-of-range source coordinates.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse: begin a frame scan; ignored unless in IDLE.
- i_abort  in  1  stop the scan; return to IDLE.
- i_angle  in  ANG_WIDTH signed  rotation angle; sampled on an accepted i_start.
- o_rot_start  out  1  one-cycle start pulse to the rotator.
- o_rot_H  out  COOR_WIDTH  screen H presented to the rotator.
- o_rot_V  out  COOR_WIDTH  screen V presented to the rotator.
- o_rot_angle  out  ANG_WIDTH signed  latched angle.
- i_rot_H  in  COOR_WIDTH  rotated source H.
- i_rot_V  in  COOR_WIDTH  rotated source V.
- i_rot_outOfRange  in  1  source coordinate lies outside the image.
- i_rot_valid  in  1  rotator result valid (single-cycle pulse).
- o_sram_req  out  1  read request; held high until ack.
- o_sram_addr  out  2*COOR_WIDTH  read address = i_rot_V*IMAGE_SIZE + i_rot_H.
- i_sram_ack  in  1  read complete; i_sram_rdata is valid in this same cycle.
- i_sram_rdata  in  PIX_WIDTH  read data.
- o_pix_valid  out  1  output pixel valid.
- i_pix_ready  in  1  downstream ready.
- o_pix_data  out  PIX_WIDTH  pixel value.
- o_pix_H  out  COOR_WIDTH  screen H of the pixel.
- o_pix_V  out  COOR_WIDTH  screen V of the pixel.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset: state IDLE. All outputs 0. Scan counters H=V=0. Latched angle 0.
- FSM states: IDLE, ISSUE, WAIT_ROT, READ, OUT, DONE.
- IDLE: on i_start, latch i_angle, clear counters, go to ISSUE. o_rot_start therefore asserts on the cycle after i_start.
- ISSUE: o_rot_start=1 for exactly one cycle with o_rot_H/V equal to the counters. Go to WAIT_ROT.
- o_rot_H/V/angle stay stable from ISSUE until i_rot_valid.
- WAIT_ROT: on i_rot_valid, capture i_rot_H, i_rot_V and i_rot_outOfRange.
  - outOfRange=1: load BG_PIXEL, go to OUT. No SRAM access.
  - otherwise: go to READ.
- READ: o_sram_req=1 with o_sram_addr stable. On i_sram_ack, capture rdata, drop req the next cycle, go to OUT.
- OUT: o_pix_valid=1 with data and H/V stable until i_pix_ready.
  - On handshake, advance H, wrapping IMAGE_SIZE-1 -> 0 and incrementing V.
  - If H=V=IMAGE_SIZE-1 at the handshake, go to DONE; otherwise go to ISSUE.
- DONE: o_done=1 for one cycle, then IDLE.
- Handshakes may complete in the same cycle they assert (ready/ack already high). Nothing is lost or duplicated.
- i_abort has priority over every other event in any non-IDLE state. Effect on the next edge:
  - state IDLE; o_sram_req, o_pix_valid and o_rot_start deasserted; no o_done.
  - A late i_rot_valid or i_sram_ack arriving in IDLE is ignored.
- i_start while busy: ignored, including in DONE.
- i_rot_valid outside WAIT_ROT, and i_sram_ack outside READ: ignored.
- Frame timing: exactly IMAGE_SIZE^2 pixel handshakes per frame in raster order, V outer, H inner.
- Address arithmetic: unsigned concatenation {V,H}; no overflow is possible.
- Reset mid-frame: immediate return to the reset state; the next frame restarts at (0,0).

Decomposition:
- Add to sram_pkg (alongside IMAGE_SIZE and IMAGE_COOR_WIDTH): PIX_WIDTH, BG_PIXEL, and an address typedef of width 2*IMAGE_COOR_WIDTH.
- FSM state enum goes in game_pkg.
- One natural sub-module: raster_counter (H/V counter with advance, clear and last flag).
- The rotator is instantiated by the parent, not inside this block.

Test Plan:
- IMAGE_SIZE=4, angle 0, identity rotator model, ack 2 cycles after req, ready always high -> 16 reads at addr 0..15 in order; o_pix_data matches the SRAM model; o_done pulses once, one cycle after the 16th handshake; o_busy then drops.
- Rotator flags outOfRange for screen (0,0) and (3,3) -> no o_sram_req for those pixels; o_pix_data=16'h0000; the other 14 pixels are read normally.
- i_pix_ready held low 5 cycles on pixel (2,1) -> o_pix_valid, data and H/V stable for all 5 cycles; no new o_rot_start until the handshake.
- i_start pulsed again during WAIT_ROT with i_angle=90 -> ignored; o_rot_angle keeps the original value; frame completes with 16 pixels.
- i_abort while in READ -> next cycle o_sram_req=0 and o_busy=0; a late ack is ignored; no o_done. A new i_start restarts at (0,0).
- i_rst asserted mid-frame at pixel 7 -> all outputs 0 asynchronously. After release, i_start with angle -45 -> first o_rot_H/V=(0,0) and o_rot_angle=-45.

Source files
------------

// File: rtl/rotate_scan_ctrl_pkg.sv
// Shared constants for the rotated-image scan controller.
// Holds the default image geometry, pixel format, background pixel,
// the SRAM address type and the scan FSM state encodings.
package rotate_scan_ctrl_pkg;

  // Image geometry and pixel format
  localparam int IMAGE_SIZE       = 128;
  localparam int IMAGE_COOR_WIDTH = 7;
  localparam int ANG_WIDTH        = 9;
  localparam int PIX_WIDTH        = 16;

  localparam logic [PIX_WIDTH-1:0] BG_PIXEL = 16'h0000;

  typedef logic [2*IMAGE_COOR_WIDTH-1:0] sram_addr_t;

  // Scan FSM states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_ROT = 3'd2;
  localparam logic [2:0] ST_READ     = 3'd3;
  localparam logic [2:0] ST_OUT      = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/rotate_scan_ctrl_raster_counter.sv
// Raster H/V counter for the screen scan.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clear     : return to (0,0)
//   advance   : step H, wrapping to 0 and stepping V at the row end
//   h, v      : current screen coordinate
//   last      : current coordinate is the final pixel of the frame
module rotate_scan_ctrl_raster_counter #(
  parameter int IMAGE_SIZE = 128,
  parameter int COOR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [COOR_WIDTH-1:0] h,
  output logic [COOR_WIDTH-1:0] v,
  output logic                  last
);

  localparam logic [COOR_WIDTH-1:0] EDGE_MAX = COOR_WIDTH'(IMAGE_SIZE - 1);

  logic h_last;
  logic v_last;

  assign h_last = (h == EDGE_MAX);
  assign v_last = (v == EDGE_MAX);
  assign last   = h_last && v_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (clear) begin
      h <= '0;
      v <= '0;
    end else if (advance) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rotate_scan_ctrl.sv
// Scan controller driving an external rotate-coordinate unit.
// For every screen pixel in raster order it asks the rotator for the
// source coordinate, reads that pixel from image SRAM (or substitutes the
// background pixel when the source is out of range) and streams the result
// to the frame writer.
// Ports:
//   i_clk, i_rst                      : clock, asynchronous active-high reset
//   i_start, i_abort, i_angle         : frame control from game logic
//   o_rot_* / i_rot_*                 : request/result to the rotator
//   o_sram_req/addr, i_sram_ack/rdata : image SRAM read handshake
//   o_pix_* / i_pix_ready             : pixel stream to the frame writer
//   o_busy, o_done                    : frame status
module rotate_scan_ctrl
  import rotate_scan_ctrl_pkg::*;
#(
  parameter int IMAGE_SIZE = rotate_scan_ctrl_pkg::IMAGE_SIZE,
  parameter int COOR_WIDTH = rotate_scan_ctrl_pkg::IMAGE_COOR_WIDTH,
  parameter int ANG_WIDTH  = rotate_scan_ctrl_pkg::ANG_WIDTH,
  parameter int PIX_WIDTH  = rotate_scan_ctrl_pkg::PIX_WIDTH,
  parameter logic [PIX_WIDTH-1:0] BG_PIXEL = rotate_scan_ctrl_pkg::BG_PIXEL
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic signed [ANG_WIDTH-1:0] i_angle,
  output logic                        o_rot_start,
  output logic [COOR_WIDTH-1:0]       o_rot_H,
  output logic [COOR_WIDTH-1:0]       o_rot_V,
  output logic signed [ANG_WIDTH-1:0] o_rot_angle,
  input  logic [COOR_WIDTH-1:0]       i_rot_H,
  input  logic [COOR_WIDTH-1:0]       i_rot_V,
  input  logic                        i_rot_outOfRange,
  input  logic                        i_rot_valid,
  output logic                        o_sram_req,
  output logic [2*COOR_WIDTH-1:0]     o_sram_addr,
  input  logic                        i_sram_ack,
  input  logic [PIX_WIDTH-1:0]        i_sram_rdata,
  output logic                        o_pix_valid,
  input  logic                        i_pix_ready,
  output logic [PIX_WIDTH-1:0]        o_pix_data,
  output logic [COOR_WIDTH-1:0]       o_pix_H,
  output logic [COOR_WIDTH-1:0]       o_pix_V,
  output logic                        o_busy,
  output logic                        o_done
);

  logic [2:0]                  state;
  logic signed [ANG_WIDTH-1:0] angle_q;
  logic [2*COOR_WIDTH-1:0]     addr_q;
  logic [PIX_WIDTH-1:0]        pix_q;

  logic [COOR_WIDTH-1:0] scan_h;
  logic [COOR_WIDTH-1:0] scan_v;
  logic                  scan_last;
  logic                  scan_clear;
  logic                  scan_advance;
  logic                  aborting;
  logic                  pix_hs;

  // Abort wins over any handshake completing in the same cycle, so a
  // pixel accepted while aborting must not move the counters either.
  assign aborting     = i_abort && (state != ST_IDLE);
  assign pix_hs       = (state == ST_OUT) && i_pix_ready;
  assign scan_clear   = (state == ST_IDLE) && i_start;
  assign scan_advance = pix_hs && !aborting;

  rotate_scan_ctrl_raster_counter #(
    .IMAGE_SIZE (IMAGE_SIZE),
    .COOR_WIDTH (COOR_WIDTH)
  ) u_raster (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (scan_clear),
    .advance (scan_advance),
    .h       (scan_h),
    .v       (scan_v),
    .last    (scan_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      angle_q <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
    end else if (aborting) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            angle_q <= i_angle;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_ROT;
        end
        ST_WAIT_ROT: begin
          if (i_rot_valid) begin
            // Image edge is a power of two, so {V,H} is V*IMAGE_SIZE+H.
            addr_q <= {i_rot_V, i_rot_H};
            if (i_rot_outOfRange) begin
              pix_q <= BG_PIXEL;
              state <= ST_OUT;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (i_sram_ack) begin
            pix_q <= i_sram_rdata;
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (pix_hs) begin
            state <= scan_last ? ST_DONE : ST_ISSUE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake strobes decode straight from the state so that they all
  // read 0 whenever the controller sits in IDLE (reset or abort).
  assign o_rot_start = (state == ST_ISSUE);
  assign o_rot_H     = scan_h;
  assign o_rot_V     = scan_v;
  assign o_rot_angle = angle_q;
  assign o_sram_req  = (state == ST_READ);
  assign o_sram_addr = addr_q;
  assign o_pix_valid = (state == ST_OUT);
  assign o_pix_data  = pix_q;
  assign o_pix_H     = scan_h;
  assign o_pix_V     = scan_v;
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_DONE);

endmodule
